// File: rtl/store_datapath.sv
// Store-side datapath: formats SB/SH/SW requests into lane-shifted words with byte
// strobes and drains them in order from a small FIFO over a req/ack handshake.
module store_datapath #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [1:0]  store_type,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic        st_misalign,
  output logic        sb_empty,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [29:0] addr_mem [DEPTH];
  logic [31:0] data_mem [DEPTH];
  logic [3:0]  strb_mem [DEPTH];

  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;

  logic        legal, accept, push, pop;
  logic [31:0] fmt_data;
  logic [3:0]  fmt_strb;

  assign st_ready = (count != FULL);
  assign sb_empty = (count == '0);
  assign mem_req  = !sb_empty;
  assign accept   = st_valid & st_ready;
  assign push     = accept & legal;
  assign pop      = mem_req & mem_ack;

  always_comb begin
    legal    = 1'b0;
    fmt_data = '0;
    fmt_strb = '0;
    case (store_type)
      2'b00: begin
        legal    = 1'b1;
        fmt_data = {4{wr_data[7:0]}};
        fmt_strb = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        legal    = !addr[0];
        fmt_data = {2{wr_data[15:0]}};
        fmt_strb = addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        legal    = (addr[1:0] == 2'b00);
        fmt_data = wr_data;
        fmt_strb = 4'b1111;
      end
      default: legal = 1'b0;
    endcase
  end

  // Payload storage carries no reset; validity is tracked solely by count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail] <= addr[31:2];
      data_mem[tail] <= fmt_data;
      strb_mem[tail] <= fmt_strb;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      st_misalign <= 1'b0;
    end else begin
      st_misalign <= accept & !legal;
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  assign mem_addr  = mem_req ? {addr_mem[head], 2'b00} : '0;
  assign mem_wdata = mem_req ? data_mem[head] : '0;
  assign mem_wstrb = mem_req ? strb_mem[head] : '0;

endmodule
